// File: rtl/rf_wport_sched.sv
// rf_wport_sched: single register-file write port shared between the in-order
// WB stage (fixed priority) and one long-latency unit. A busy scoreboard of LU
// destinations feeds decode hazard checks; a starvation counter forces a
// one-cycle WB stall so the LU always retires.
module rf_wport_sched #(
    parameter int MAX_PENDING = 4,
    parameter int STARVE_MAX  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wren,
    input  logic [4:0]  pipe_wraddr,
    input  logic [31:0] pipe_wrdata,
    output logic        pipe_stall,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_addr,
    output logic        lu_issue_ok,
    input  logic        lu_valid,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic [4:0]  chk1addr,
    input  logic [4:0]  chk2addr,
    output logic        chk1busy,
    output logic        chk2busy,
    output logic        rf_wren,
    output logic [4:0]  rf_wraddr,
    output logic [31:0] rf_wrdata,
    output logic        err_waw
);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {ARB, FORCE} state_t;

    state_t        state, state_nxt;
    logic [31:0]   busy, busy_nxt;
    logic [PW-1:0] pend_cnt, pend_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic          pipe_grant, issue_fire, lu_acc, err_set;

    // FORCE lasts exactly one cycle, so the stall is simply the state flop.
    assign pipe_stall  = (state == FORCE);
    // r0 is never marked busy, so it may always be issued while slots remain.
    assign lu_issue_ok = (pend_cnt < PW'(MAX_PENDING)) &&
                         (!busy[lu_issue_addr] || lu_issue_addr == 5'd0);
    assign issue_fire  = lu_issue && lu_issue_ok;
    assign lu_acc      = lu_valid && lu_ready;

    // Decode sees registered busy only; an accept clears it one cycle later.
    assign chk1busy = busy[chk1addr];
    assign chk2busy = busy[chk2addr];

    assign rf_wren   = lu_ready || pipe_grant;
    assign rf_wraddr = lu_ready ? lu_addr : pipe_wraddr;
    assign rf_wrdata = lu_ready ? lu_data : pipe_wrdata;

    // Arbitration: pipeline wins in ARB; LU wins when pipe idle or when forced.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        lu_ready   = 1'b0;
        pipe_grant = 1'b0;
        case (state)
            ARB: begin
                if (lu_valid && !pipe_wren) begin
                    lu_ready   = 1'b1;
                    starve_nxt = '0;
                end else if (pipe_wren) begin
                    pipe_grant = 1'b1;
                    if (lu_valid) begin
                        starve_nxt = starve_cnt + 1'b1;
                        if (starve_cnt == SW'(STARVE_MAX - 1))
                            state_nxt = FORCE;
                    end
                end else begin
                    starve_nxt = '0;
                end
            end
            FORCE: begin
                // LU is held valid by protocol; gate anyway so a flushed LU never writes.
                lu_ready   = lu_valid;
                starve_nxt = '0;
                state_nxt  = ARB;
            end
            default: state_nxt = ARB;
        endcase
        if (rst) begin
            lu_ready   = 1'b0;
            pipe_grant = 1'b0;
        end
    end

    // Scoreboard next-state and protocol-violation detection.
    always_comb begin
        busy_nxt = busy;
        if (issue_fire && lu_issue_addr != 5'd0)
            busy_nxt[lu_issue_addr] = 1'b1;
        if (lu_acc)
            busy_nxt[lu_addr] = 1'b0;
        busy_nxt[0] = 1'b0;

        pend_nxt = pend_cnt;
        if (issue_fire && !lu_acc)
            pend_nxt = pend_cnt + 1'b1;
        else if (!issue_fire && lu_acc && pend_cnt != '0)
            pend_nxt = pend_cnt - 1'b1;

        err_set = (lu_issue && !lu_issue_ok) ||
                  (pipe_grant && pipe_wraddr != 5'd0 && busy[pipe_wraddr]) ||
                  (lu_acc && pend_cnt == '0);
    end

    // State registers; reset discards all pending LU bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB;
            busy       <= '0;
            pend_cnt   <= '0;
            starve_cnt <= '0;
            err_waw    <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= busy_nxt;
            pend_cnt   <= pend_nxt;
            starve_cnt <= starve_nxt;
            err_waw    <= err_waw || err_set;
        end
    end

endmodule

// File: tb/tb_rf_wport_sched.sv
// Self-checking bench for rf_wport_sched: directed scenarios followed by a
// randomized phase, all compared each cycle against a transaction-level model.
module tb_rf_wport_sched;
    localparam int MAXP = 4;
    localparam int SMAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_wren = 1'b0;
    logic [4:0]  pipe_wraddr = '0;
    logic [31:0] pipe_wrdata = '0;
    logic        pipe_stall;
    logic        lu_issue = 1'b0;
    logic [4:0]  lu_issue_addr = '0;
    logic        lu_issue_ok;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_addr = '0;
    logic [31:0] lu_data = '0;
    logic        lu_ready;
    logic [4:0]  chk1addr = '0;
    logic [4:0]  chk2addr = '0;
    logic        chk1busy, chk2busy;
    logic        rf_wren;
    logic [4:0]  rf_wraddr;
    logic [31:0] rf_wrdata;
    logic        err_waw;

    rf_wport_sched #(.MAX_PENDING(MAXP), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .pipe_wren(pipe_wren), .pipe_wraddr(pipe_wraddr), .pipe_wrdata(pipe_wrdata),
        .pipe_stall(pipe_stall),
        .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr), .lu_issue_ok(lu_issue_ok),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
        .chk1addr(chk1addr), .chk2addr(chk2addr), .chk1busy(chk1busy), .chk2busy(chk2busy),
        .rf_wren(rf_wren), .rf_wraddr(rf_wraddr), .rf_wrdata(rf_wrdata),
        .err_waw(err_waw)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: set of busy registers, count of outstanding LU ops,
    // count of consecutive LU losses, and whether the next cycle is a forced LU slot.
    bit [31:0] m_busy;
    int        m_pend;
    int        m_losses;
    bit        m_force;
    bit        m_err;
    bit        m_acc;
    bit        obs_stall, obs_pgrant;
    logic [4:0] q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ok(input logic [4:0] a);
        return (m_pend < MAXP) && (a == 5'd0 || !m_busy[a]);
    endfunction

    task automatic model_reset();
        m_busy = '0; m_pend = 0; m_losses = 0; m_force = 0; m_err = 0; q.delete();
    endtask

    // One clock: check comb/registered outputs mid-cycle, then advance the model.
    task automatic cycle();
        bit ok, g_lu, g_pipe;
        ok     = m_ok(lu_issue_addr);
        g_lu   = m_force ? lu_valid : (lu_valid && !pipe_wren);
        g_pipe = !m_force && pipe_wren && !g_lu;
        @(negedge clk);
        check("pipe_stall", pipe_stall, m_force);
        check("lu_issue_ok", lu_issue_ok, ok);
        check("lu_ready", lu_ready, g_lu);
        check("rf_wren", rf_wren, g_lu | g_pipe);
        if (g_lu) begin
            check("rf_wraddr_lu", rf_wraddr, lu_addr);
            check("rf_wrdata_lu", rf_wrdata, lu_data);
        end else if (g_pipe) begin
            check("rf_wraddr_pipe", rf_wraddr, pipe_wraddr);
            check("rf_wrdata_pipe", rf_wrdata, pipe_wrdata);
        end
        check("chk1busy", chk1busy, m_busy[chk1addr] && chk1addr != 5'd0);
        check("chk2busy", chk2busy, m_busy[chk2addr] && chk2addr != 5'd0);
        check("err_waw", err_waw, m_err);
        obs_stall  = pipe_stall;
        obs_pgrant = rf_wren && !lu_ready;
        m_acc      = g_lu;
        @(posedge clk);
        if (lu_issue && !ok) m_err = 1;
        if (g_pipe && pipe_wraddr != 5'd0 && m_busy[pipe_wraddr]) m_err = 1;
        if (g_lu && m_pend == 0) m_err = 1;
        if (lu_issue && ok) begin
            if (lu_issue_addr != 5'd0) m_busy[lu_issue_addr] = 1'b1;
            m_pend++;
        end
        if (g_lu) begin
            m_busy[lu_addr] = 1'b0;
            if (m_pend > 0) m_pend--;
        end
        if (m_force) begin
            m_force = 0; m_losses = 0;
        end else if (lu_valid && pipe_wren) begin
            m_losses++;
            if (m_losses == SMAX) m_force = 1;
        end else if (lu_valid || !pipe_wren) begin
            m_losses = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; lu_valid = 1'b1; pipe_wren = 1'b1; lu_issue = 1'b0;
        @(negedge clk);
        check("rst_rf_wren", rf_wren, 1'b0);
        check("rst_lu_ready", lu_ready, 1'b0);
        check("rst_pipe_stall", pipe_stall, 1'b0);
        check("rst_chk1busy", chk1busy, 1'b0);
        check("rst_chk2busy", chk2busy, 1'b0);
        check("rst_err_waw", err_waw, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; lu_valid = 1'b0; pipe_wren = 1'b0;
        model_reset();
    endtask

    task automatic issue(input logic [4:0] a);
        lu_issue = 1'b1; lu_issue_addr = a;
        cycle();
        lu_issue = 1'b0;
    endtask

    task automatic lu_return(input logic [4:0] a, input logic [31:0] d);
        bit done;
        done = 0;
        lu_valid = 1'b1; lu_addr = a; lu_data = d;
        for (int i = 0; i < 12 && !done; i++) begin
            cycle();
            done = m_acc;
        end
        lu_valid = 1'b0;
        check("lu_return_done", done, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done, stall_at_acc, ok_pre;
        int n_pipe;
        model_reset();
        chk1addr = 5'd5; chk2addr = 5'd7;
        do_reset();

        // LU round trip on r5 with idle pipe.
        chk1addr = 5'd5;
        issue(5'd5);
        repeat (3) cycle();
        lu_return(5'd5, 32'hDEADBEEF);
        cycle();

        // Contention: LU held while pipe writes every cycle.
        issue(5'd9);
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h0BAD_F00D;
        pipe_wren = 1'b1; pipe_wraddr = 5'd10; pipe_wrdata = 32'h1234_5678;
        n_pipe = 0; done = 0; stall_at_acc = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            if (obs_pgrant) n_pipe++;
            done = m_acc;
            if (done) stall_at_acc = obs_stall;
        end
        lu_valid = 1'b0;
        check("starve_done", done, 1'b1);
        check("starve_pipe_wins", n_pipe, SMAX);
        check("starve_forced_stall", stall_at_acc, 1'b1);
        cycle();
        pipe_wren = 1'b0;
        cycle();

        // Fill to MAX_PENDING, then accept+issue in the same cycle.
        for (int r = 1; r <= 4; r++) issue(5'(r));
        lu_issue_addr = 5'd6;
        cycle();
        lu_valid = 1'b1; lu_addr = 5'd1; lu_data = 32'h1111_1111;
        lu_issue = 1'b1; lu_issue_addr = 5'd6;
        cycle();
        lu_valid = 1'b0; lu_issue = 1'b0;
        chk1addr = 5'd1; chk2addr = 5'd6; lu_issue_addr = 5'd8;
        cycle();
        lu_return(5'd2, 32'h2222_2222);
        lu_return(5'd3, 32'h3333_3333);
        lu_return(5'd4, 32'h4444_4444);
        lu_return(5'd6, 32'h6666_6666);
        cycle();

        // Double issue of r7, then reset with r7 still pending.
        chk1addr = 5'd7;
        issue(5'd7);
        issue(5'd7);
        cycle();
        do_reset();

        // Pipe write to a busy register.
        issue(5'd11);
        pipe_wren = 1'b1; pipe_wraddr = 5'd11; pipe_wrdata = 32'hAAAA_5555;
        cycle();
        pipe_wren = 1'b0;
        cycle();
        do_reset();

        // LU accept with nothing pending.
        lu_return(5'd3, 32'h0000_0033);
        cycle();
        do_reset();

        // r0 round trip: accepted and written, never busy, no error.
        chk1addr = 5'd0;
        issue(5'd0);
        lu_return(5'd0, 32'hC0FF_EE00);
        cycle();
        for (int r = 12; r < 16; r++) issue(5'(r));
        lu_issue_addr = 5'd20;
        cycle();
        do_reset();

        // Randomized traffic with an in-order LU returning pending ops.
        for (int n = 0; n < 1500; n++) begin
            pipe_wren     = ($urandom_range(0, 9) < 7);
            pipe_wraddr   = 5'($urandom);
            pipe_wrdata   = $urandom;
            lu_issue      = ($urandom_range(0, 3) == 0);
            lu_issue_addr = 5'($urandom);
            chk1addr      = 5'($urandom);
            chk2addr      = 5'($urandom);
            if (!lu_valid && q.size() > 0 && $urandom_range(0, 1) == 1) begin
                lu_valid = 1'b1; lu_addr = q[0]; lu_data = $urandom;
            end
            ok_pre = m_ok(lu_issue_addr);
            cycle();
            if (m_acc) begin
                void'(q.pop_front());
                lu_valid = 1'b0;
            end
            if (lu_issue && ok_pre) q.push_back(lu_issue_addr);
        end
        lu_issue = 1'b0; pipe_wren = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
